// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 4-digit display scanner.
package display_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_prescaler.sv
// Per-slot cycle counter: counts 0..CLK_DIV-1, flags the last cycle of each slot.
module display_prescaler #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_slot_end
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_slot_end;

  assign w_slot_end = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_slot_end = w_slot_end;

endmodule

// File: rtl/display_scan.sv
// Time-multiplexes a 16-bit packed-BCD value onto a 4-digit display with a
// blanking gap at the start of every slot and optional leading-zero blanking.
module display_scan
  import display_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  scan_state_t      r_state;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_hold;
  logic [15:0]      r_disp;
  logic [3:0]       r_an;
  logic [3:0]       r_digit;
  logic             r_frame_done;

  logic [CNT_W-1:0] w_cnt;
  logic             w_slot_end;
  logic             w_blank_end;
  logic             w_first_blank;
  logic [15:0]      w_disp_next;
  logic [3:0]       w_zero_from;
  logic [3:0]       w_sel;

  display_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_cnt      (w_cnt),
    .o_slot_end (w_slot_end)
  );

  assign w_blank_end   = (w_cnt == CNT_W'(BLANK_CYC - 1));
  assign w_first_blank = (r_state == BLANK) && (w_cnt == '0);

  // Forwarding the slot snapshot keeps BLANK_CYC=1 correct, where the copy
  // and the first digit update land on the same edge.
  assign w_disp_next = w_first_blank ? r_hold : r_disp;

  always_comb begin
    w_zero_from    = '0;
    w_zero_from[3] = (w_disp_next[15:12] == 4'h0);
    w_zero_from[2] = w_zero_from[3] && (w_disp_next[11:8] == 4'h0);
    w_zero_from[1] = w_zero_from[2] && (w_disp_next[7:4] == 4'h0);
    w_zero_from[0] = w_zero_from[1] && (w_disp_next[3:0] == 4'h0);
  end

  assign w_sel = (lz_en && (r_idx != '0) && w_zero_from[r_idx])
               ? BLANK_CODE
               : w_disp_next[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BLANK;
      r_idx        <= '0;
      r_hold       <= '0;
      r_disp       <= '0;
      r_an         <= 4'b1111;
      r_digit      <= BLANK_CODE;
      r_frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_hold <= value;
      end
      r_disp       <= w_disp_next;
      r_frame_done <= 1'b0;
      case (r_state)
        BLANK: begin
          if (w_blank_end) begin
            r_state <= SHOW;
            r_an    <= ~(4'b0001 << r_idx);
            r_digit <= w_sel;
          end
        end
        SHOW: begin
          if (w_slot_end) begin
            r_state      <= BLANK;
            r_an         <= 4'b1111;
            r_digit      <= BLANK_CODE;
            r_idx        <= r_idx + 1'b1;
            r_frame_done <= (r_idx == IDX_W'(NUM_DIGITS - 1));
          end else begin
            r_digit <= w_sel;
          end
        end
        default: begin
          r_state <= BLANK;
        end
      endcase
    end
  end

  assign an         = r_an;
  assign digit      = r_digit;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: expected outputs are derived from slot
// arithmetic on the cycle count since reset and queued per target cycle.
module tb_display_scan;

  localparam int D    = 8;
  localparam int B    = 2;
  localparam int MAXC = 4096;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        load  = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  display_scan #(.CLK_DIV(D), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .lz_en      (lz_en),
    .digit      (digit),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tag;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        fd;
  } exp_t;

  exp_t        sbq[$];
  int unsigned gcyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] hist_hold [MAXC];
  logic        hist_lz   [MAXC];
  int          t;
  logic [15:0] cur_hold;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d t=%0d actual=%h expected=%h", name, gcyc, t, act, exp);
    end
  endtask

  // Digit i is blank when lz is on, i>=1, and no nonzero nibble sits at or above i.
  function automatic logic [3:0] ref_sel(input logic [15:0] v, input int i, input logic lz);
    int msd;
    msd = -1;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) msd = k;
    if (lz && i >= 1 && i > msd) return 4'hF;
    return v[4*i +: 4];
  endfunction

  // Output seen during cycle tt since reset release.
  function automatic exp_t ref_out(input int tt);
    exp_t e;
    int   s, pos, idx;
    s     = tt / D;
    pos   = tt % D;
    idx   = s % 4;
    e.tag = 0;
    e.fd  = (pos == 0) && (s >= 4) && (idx == 0);
    if (pos < B) begin
      e.an    = 4'hF;
      e.digit = 4'hF;
    end else begin
      e.an      = 4'hF;
      e.an[idx] = 1'b0;
      e.digit   = ref_sel(hist_hold[s*D], idx, hist_lz[tt-1]);
    end
    return e;
  endfunction

  task automatic begin_epoch();
    exp_t e;
    rst      = 1'b0;
    t        = 0;
    cur_hold = 16'h0;
    e        = ref_out(0);
    e.tag    = gcyc;
    sbq.push_back(e);
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic lz);
    exp_t e;
    if (t + 1 >= MAXC) begin
      $display("FAIL bench_capacity t=%0d limit=%0d", t, MAXC);
      $fatal(1, "history overflow");
    end
    load         = ld;
    value        = v;
    lz_en        = lz;
    hist_hold[t] = cur_hold;
    hist_lz[t]   = lz;
    if (ld) cur_hold = v;
    e     = ref_out(t + 1);
    e.tag = gcyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    t++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0 && sbq[0].tag < gcyc) begin
      failures++;
      $display("FAIL sb_stale tag=%0d cyc=%0d", sbq[0].tag, gcyc);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].tag == gcyc) begin
      e = sbq.pop_front();
      chk("an", an, e.an);
      chk("digit", digit, e.digit);
      chk("frame_done", {3'b000, frame_done}, {3'b000, e.fd});
    end
  end

  initial begin
    logic        ld;
    logic        lzr;
    logic [15:0] v;
    t        = 0;
    cur_hold = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_digit", digit, 4'hF);
    chk("rst_fd", {3'b000, frame_done}, 4'h0);
    begin_epoch();

    repeat (96) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    repeat (70) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h0050, 1'b1);
    repeat (70) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    repeat (70) step(1'b0, 16'h0, 1'b1);

    // Load mid-way through digit 2's show phase; digit 2 must keep its old nibble.
    step(1'b1, 16'h5678, 1'b0);
    while (t % (4*D) != 2*D + 4) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h9999, 1'b0);
    repeat (40) step(1'b0, 16'h0, 1'b0);

    // Async reset pulse during digit 1's show phase.
    while (t % (4*D) != D + 4) step(1'b0, 16'h0, 1'b0);
    chk("pre_rst_an", an, 4'b1101);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("midrst_an", an, 4'hF);
    chk("midrst_digit", digit, 4'hF);
    chk("midrst_fd", {3'b000, frame_done}, 4'h0);
    @(posedge clk);
    #1;
    begin_epoch();

    step(1'b1, 16'hAB07, 1'b1);
    repeat (70) step(1'b0, 16'h0, 1'b1);

    lzr = 1'b0;
    repeat (800) begin
      ld = ($urandom_range(0, 19) == 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) lzr = ~lzr;
      step(ld, v, lzr);
    end

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Upstream driver for the team's BCD-to-seven-segment decoder in a 4-digit multiplexed display.
- Holds a 16-bit packed-BCD value and time-multiplexes one digit at a time. Drives the 4-bit digit code into the decoder and the active-low digit anodes.
- Inserts an all-off blanking gap between digits to prevent ghosting. Optionally suppresses leading zeros by sending code 4'hF, which the decoder turns into all segments off.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot, including the blank gap; legal range 4..2^20.
- BLANK_CYC, 16, cycles of the blank gap at the start of each slot; legal range 1..CLK_DIV-2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value.
- value  in  16  packed BCD: [15:12] digit 3 (MSD) … [3:0] digit 0 (LSD).
- lz_en  in  1  leading-zero blanking enable; level, sampled every cycle.
- digit  out  4  code to the decoder; 4'hF means blank.
- an  out  4  anode enables, active low; an[i]=0 lights digit i.
- frame_done  out  1  one-cycle pulse at the end of the digit-3 slot.

Behaviour:
- Reset (async assert, sync release): an=4'b1111, digit=4'hF, frame_done=0, hold_q=0, disp_q=0, idx=0, prescaler=0, state=BLANK.
- Registers: hold_q (16b) captures value on any cycle with load=1; last load wins. disp_q (16b) copies hold_q on the first cycle of every BLANK phase, so a digit never changes mid-slot.
- Prescaler: counts 0..CLK_DIV-1 per slot and wraps to 0. Width is clog2(CLK_DIV).
- FSM, two states:
  - BLANK: an=4'b1111, digit=4'hF. When prescaler==BLANK_CYC-1, go to SHOW.
  - SHOW: an = ~(4'b0001<<idx), digit = sel(idx). When prescaler==CLK_DIV-1: idx<=idx+1 mod 4 (3 wraps to 0), go to BLANK.
- Slot length is exactly CLK_DIV cycles. Frame length is 4*CLK_DIV cycles.
- Outputs are registered: an and digit take their new values one cycle after the state/prescaler condition. No combinational path from inputs to outputs.
- sel(i):
  - Returns the disp_q nibble i by default.
  - Returns 4'hF if lz_en=1, i>=1, and every nibble from i up to 3 is 0.
  - Digit 0 is never blanked, so 0x0000 with lz_en shows "0".
- Non-BCD nibbles (A–F) pass through unchanged. The decoder blanks them.
- frame_done = 1 for exactly the cycle in which the idx 3→0 transition is registered.
- load coinciding with the first BLANK cycle: disp_q takes the old hold_q. The new value appears from the next slot.
- rst asserted mid-slot: outputs go to reset values immediately, with no partial slot completion. Scanning restarts at digit 0 with a BLANK phase.
- lz_en toggling mid-slot: takes effect on the next registered digit update.

Decomposition:
- Shared package display_pkg:
  - constant BLANK_CODE = 4'hF.
  - constant NUM_DIGITS = 4.
  - typedef scan_state_t {BLANK, SHOW}.
- One natural sub-module, display_prescaler: a parameterised slot counter that outputs cnt and a slot_end pulse. The lead-zero mask is plain combinational logic inside display_scan.

Test Plan:
- Reset, then run 3 frames with no load (CLK_DIV=8, BLANK_CYC=2) → an sequence 1111×2, 1110×6, 1111×2, 1101×6, … ; digit=0 during each SHOW; frame_done pulses every 32 cycles.
- load value=16'h1234, lz_en=0 → from the next slot, digits 0..3 show 4, 3, 2, 1 with matching an; digit=F in every blank gap.
- lz_en=1, value=16'h0050 → digit 3 = F, digit 2 = F, digit 1 = 5, digit 0 = 0. With value=16'h0000, only digit 0 shows 0 and the rest are F.
- Mid-slot: load 16'h9999 while digit 2 is showing → digit 2 keeps its old nibble until its slot ends; the next slot (digit 3) shows 9.
- Assert rst for 1 cycle during SHOW of digit 1 → same cycle, an=1111 and digit=F; after release, an=1111 for 2 cycles, then 1110.
- value=16'hAB07 → digit 3 = A and digit 2 = B are passed through unchanged, with no lead-zero suppression applied to them.
